// File: rtl/mem_bus_master_if.sv
// mem_bus_master_if
// Bundles the control-unit request/response signals and the ROM+RAM memory
// bus that mem_bus_master sequences.
//   Request side : req, req_wr, req_addr[7:0], req_len[2:0], req_wdata[15:0]
//   Response side: busy, rdata[15:0], rvalid, done, err
//   Memory side  : mem_addr[7:0], mem_wr, mem_wdata[15:0], mem_rdata[15:0]
// modport master : the sequencing initiator (mem_bus_master).
// modport slave  : everything around it (control unit plus memory responder).
interface mem_bus_master_if;
  logic        req;
  logic        req_wr;
  logic [7:0]  req_addr;
  logic [2:0]  req_len;
  logic [15:0] req_wdata;
  logic        busy;
  logic [15:0] rdata;
  logic        rvalid;
  logic        done;
  logic        err;
  logic [7:0]  mem_addr;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport master (
    input  req, req_wr, req_addr, req_len, req_wdata, mem_rdata,
    output busy, rdata, rvalid, done, err, mem_addr, mem_wr, mem_wdata
  );

  modport slave (
    output req, req_wr, req_addr, req_len, req_wdata, mem_rdata,
    input  busy, rdata, rvalid, done, err, mem_addr, mem_wr, mem_wdata
  );
endinterface

// File: rtl/mem_bus_master.sv
// mem_bus_master
// Sequencing initiator for the 8-bit-address / 16-bit-data ROM+RAM block.
// Accepts a single or burst (1..8 words) read/write request while idle and
// walks each word through SETUP -> ACCESS (WAIT_CYCLES) -> HOLD, so the
// address is stable a full cycle either side of the write strobe. Writes to
// the read-only window 0..ROM_TOP are suppressed per word and flagged in err.
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mem_bus_master_if.master (request, response and memory signals)
// Every output is driven straight from a flop.
module mem_bus_master #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [7:0]  ROM_TOP     = 8'h3F
) (
  input logic              clk,
  input logic              rst_n,
  mem_bus_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // ACCESS lasts wait_r+1 cycles, so the counter starts one below the width.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_r,  state_s;
  logic        wr_r,     wr_s;
  logic [2:0]  remain_r, remain_s;
  logic [3:0]  wait_r,   wait_s;
  logic [7:0]  addr_r,   addr_s;
  logic [15:0] wdata_r,  wdata_s;
  logic        mem_wr_r, mem_wr_s;
  logic [15:0] rdata_r,  rdata_s;
  logic        rvalid_r, rvalid_s;
  logic        done_r,   done_s;
  logic        busy_r,   busy_s;
  logic        err_r,    err_s;
  logic        ram_hit_s;

  // Write permission is decided per word from the current address.
  assign ram_hit_s = (addr_r > ROM_TOP);

  // Next-state and next-output logic; all outputs are pre-computed here so
  // they can be registered and reach the pins one cycle later.
  always_comb begin
    state_s  = state_r;
    wr_s     = wr_r;
    remain_s = remain_r;
    wait_s   = wait_r;
    addr_s   = addr_r;
    wdata_s  = wdata_r;
    mem_wr_s = 1'b0;
    rdata_s  = rdata_r;
    rvalid_s = 1'b0;
    done_s   = 1'b0;
    busy_s   = busy_r;
    err_s    = err_r;

    case (state_r)
      IDLE: begin
        if (bus.req) begin
          state_s  = SETUP;
          wr_s     = bus.req_wr;
          addr_s   = bus.req_addr;
          wdata_s  = bus.req_wdata;
          remain_s = bus.req_len;
          err_s    = 1'b0;
          busy_s   = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end

      SETUP: begin
        state_s = ACCESS;
        wait_s  = WAIT_LOAD;
        if (wr_r && ram_hit_s) begin
          mem_wr_s = 1'b1;
        end else begin
          mem_wr_s = 1'b0;
        end
        if (wr_r && !ram_hit_s) begin
          err_s = 1'b1;
        end else begin
          err_s = err_r;
        end
      end

      ACCESS: begin
        if (wait_r == 4'd0) begin
          // Last ACCESS edge: strobe falls, read data is captured.
          state_s  = HOLD;
          mem_wr_s = 1'b0;
          if (!wr_r) begin
            rdata_s  = bus.mem_rdata;
            rvalid_s = 1'b1;
          end else begin
            rdata_s  = rdata_r;
            rvalid_s = 1'b0;
          end
        end else begin
          state_s  = ACCESS;
          wait_s   = wait_r - 4'd1;
          mem_wr_s = wr_r && ram_hit_s;
        end
      end

      HOLD: begin
        if (remain_r != 3'd0) begin
          // 8-bit address wraps naturally from 8'hFF to 8'h00.
          state_s  = SETUP;
          addr_s   = addr_r + 8'd1;
          remain_s = remain_r - 3'd1;
        end else begin
          state_s  = DONE;
          done_s   = 1'b1;
        end
      end

      DONE: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end

      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers; reset drops mem_wr immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_r     <= 1'b0;
      remain_r <= 3'd0;
      wait_r   <= 4'd0;
      addr_r   <= 8'd0;
      wdata_r  <= 16'd0;
      mem_wr_r <= 1'b0;
      rdata_r  <= 16'd0;
      rvalid_r <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      wr_r     <= wr_s;
      remain_r <= remain_s;
      wait_r   <= wait_s;
      addr_r   <= addr_s;
      wdata_r  <= wdata_s;
      mem_wr_r <= mem_wr_s;
      rdata_r  <= rdata_s;
      rvalid_r <= rvalid_s;
      done_r   <= done_s;
      busy_r   <= busy_s;
      err_r    <= err_s;
    end
  end

  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.mem_wr    = mem_wr_r;
  assign bus.rdata     = rdata_r;
  assign bus.rvalid    = rvalid_r;
  assign bus.done      = done_r;
  assign bus.busy      = busy_r;
  assign bus.err       = err_r;

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Sequencing initiator for the 8-bit-address / 16-bit-data ROM+RAM memory block of the instruction-system datapath. It accepts single or short burst read/write requests from the control unit, drives the memory address, write strobe and write data with setup/hold margins and programmable wait states, and returns read data with a valid pulse. Writes that target the read-only ROM window are suppressed and flagged. It is the counterpart of the memory responder; nothing else drives that bus.

## Interface
- WAIT_CYCLES, 2: cycles per word in ACCESS (write strobe width / read settle time); legal 1..15.
- ROM_TOP, 8'h3F: highest ROM address; addresses 0..ROM_TOP are read-only.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  1  request strobe, sampled only in IDLE.
- req_wr  in  1  1 = write (fill), 0 = read.
- req_addr  in  8  start address.
- req_len  in  3  word count minus 1 (0 = 1 word, 7 = 8 words).
- req_wdata  in  16  write data; same word written to every address of a write burst.
- busy  out  1  high from SETUP of first word through DONE.
- rdata  out  16  registered read data.
- rvalid  out  1  one-cycle pulse per read word, rdata valid in same cycle.
- done  out  1  one-cycle pulse at end of request.
- err  out  1  set if any write word hit ROM; valid with done, held until next accepted req.
- mem_addr  out  8  memory address.
- mem_wr  out  1  memory write strobe, active-high.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data (combinational from address).

## Operation
- States: IDLE, SETUP, ACCESS, HOLD, DONE.
- IDLE: req=1 at a clock edge captures req_wr, req_addr, req_len, req_wdata; clears err; next state SETUP. req while not IDLE is ignored (no queueing).
- SETUP (1 cycle): mem_addr = current address, mem_wdata = captured data, mem_wr=0; wait counter loaded with WAIT_CYCLES-1.
- ACCESS (WAIT_CYCLES cycles): mem_wr=1 only if write and current address > ROM_TOP; otherwise mem_wr=0 and, for writes, err set. On the last ACCESS cycle's edge, reads register mem_rdata into rdata.
- HOLD (1 cycle): mem_wr=0, mem_addr/mem_wdata unchanged; rvalid=1 for reads. Then: words remaining -> SETUP with address+1 (mod 256, 8'hFF wraps to 8'h00), remaining count-1; else DONE.
- DONE (1 cycle): done=1, busy=1, err reflects whole request; next IDLE.
- Bursts may cross ROM/RAM boundary; write suppression is decided per word.
- mem_addr/mem_wdata hold last values in IDLE; mem_wr is 0 in every state except ACCESS.
- rdata holds last read value until the next read word.

## Timing
- Reset (async, immediate): state IDLE, mem_wr=0, mem_addr=0, mem_wdata=0, rdata=0, rvalid=0, done=0, busy=0, err=0. Reset mid-access drops mem_wr at once; the in-flight request is discarded without done.
- Per word: WAIT_CYCLES+2 cycles. Request of N words: N*(WAIT_CYCLES+2)+1 cycles from first SETUP through DONE; next req accepted in IDLE cycle after DONE.
- Single read, WAIT_CYCLES=2, req captured at edge 0: SETUP cycle 1, ACCESS 2-3, HOLD 4 (rvalid), DONE 5 (done), IDLE 6.
- mem_addr stable one full cycle before mem_wr rises and one full cycle after it falls.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset then single read req_addr=8'h05, mem_rdata model=16'h1234 -> mem_wr stays 0, rvalid+rdata=16'h1234 in cycle 4, done in cycle 5, err=0.
- Single write req_addr=8'h40, wdata=16'hBEEF, WAIT_CYCLES=2 -> mem_wr high exactly 2 cycles with mem_addr=8'h40 stable cycles 1-4; RAM reads back 16'hBEEF.
- Write fill req_addr=8'h3E, req_len=3 -> mem_wr never asserted for 8'h3E, 8'h3F; asserted for 8'h40, 8'h41; err=1 at done; next read clears err.
- Read burst req_addr=8'hFE, req_len=2 -> addresses 8'hFE, 8'hFF, 8'h00; three rvalid pulses 4 cycles apart; done at cycle 13.
- req held high continuously during a burst -> exactly one request executed per IDLE visit; no extra mem_wr pulses.
- rst_n low during ACCESS of a write -> mem_wr drops asynchronously, all outputs at reset values, no done; post-reset request runs normally.
